dcm_reset_sequencer: RTL and testbench
======================================

DCM_RESET_SEQUENCER -- requirements
Module: dcm_reset_sequencer

Interface
REQ-001 SHALL have parameter DCM_RST_CYCLES, default 128: cycles DCM_RST is held per attempt (range 2..65535).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 4096: cycles allowed for lock per attempt (range 2..65535).
REQ-003 SHALL have parameter STABLE_CYCLES, default 2048: cycles lock must hold before full release (range 2..65535).
REQ-004 SHALL have parameter MAX_RETRIES, default 3: failed attempts tolerated before FAIL (range 0..3).
REQ-005 SHALL have port PCI_CLK, input, 1: sole clock, free-running DCM input clock.
REQ-006 SHALL have port RESET_N, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port SOFT_RST, input, 1: synchronous restart request, level, PCI_CLK domain.
REQ-008 SHALL have port DCM_LOCKED, input, 1: DCM lock flag, asynchronous to PCI_CLK.
REQ-009 SHALL have port DCM_RST, output, 1: DCM reset, active-high.
REQ-010 SHALL have port WB_RST, output, 1: Wishbone domain reset, active-high.
REQ-011 SHALL have port WB_RST_DELAY, output, 1: delayed Wishbone reset, active-high.
REQ-012 SHALL have port LOCK_FAIL, output, 1: sticky lock failure flag.
REQ-013 SHALL have port RETRY_CNT, output, 2: failed attempts in current sequence.
REQ-014 SHALL have port STATE, output, 3: current state code.

Function
REQ-015 SHALL pass DCM_LOCKED through a 2-flop synchronizer; all decisions use the synchronized value lk.
REQ-016 SHALL implement states DCM_RST_S=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4; codes 5-7 unreachable, recover to DCM_RST_S.
REQ-017 SHALL use one 16-bit down/up cycle counter, cleared on every state entry.
REQ-018 DCM_RST_S: DCM_RST=1 for exactly DCM_RST_CYCLES cycles, then -> WAIT_LOCK.
REQ-019 WAIT_LOCK: DCM_RST=0; lk=1 -> STABLE next cycle; counter reaching LOCK_TIMEOUT with lk=0 -> timeout.
REQ-020 On timeout: RETRY_CNT<MAX_RETRIES -> RETRY_CNT+1, -> DCM_RST_S; else -> FAIL.
REQ-021 STABLE: WB_RST=0 from the first STABLE cycle; WB_RST_DELAY stays 1; after STABLE_CYCLES consecutive cycles of lk=1 -> RUN.
REQ-022 RUN: WB_RST=0, WB_RST_DELAY=0, RETRY_CNT cleared to 0 on entry.
REQ-023 lk=0 in STABLE or RUN: next cycle -> DCM_RST_S, WB_RST=1 and WB_RST_DELAY=1 the same cycle DCM_RST rises; RETRY_CNT unchanged (lock loss is not a retry).
REQ-024 FAIL: DCM_RST=1, WB_RST=1, WB_RST_DELAY=1, LOCK_FAIL=1; held until SOFT_RST or RESET_N.
REQ-025 SOFT_RST=1 in any state: next cycle -> DCM_RST_S, RETRY_CNT=0, LOCK_FAIL=0, WB_RST=1, WB_RST_DELAY=1; held SOFT_RST keeps the block in DCM_RST_S with counter cleared.
REQ-026 Priority, highest first: RESET_N, SOFT_RST, lock loss, timeout/count expiry.
REQ-027 All outputs SHALL be registered; WB_RST and WB_RST_DELAY never both 0 unless STATE=RUN; WB_RST_DELAY=0 implies WB_RST=0.
REQ-028 RETRY_CNT SHALL saturate, never wrap.

Reset
REQ-029 RESET_N=0 SHALL asynchronously force STATE=0, DCM_RST=1, WB_RST=1, WB_RST_DELAY=1, LOCK_FAIL=0, RETRY_CNT=0, counter=0, synchronizer flops=0.
REQ-030 Release SHALL be synchronous to PCI_CLK; the sequence restarts from DCM_RST_S with a full DCM_RST_CYCLES pulse.
REQ-031 RESET_N asserted mid-sequence SHALL abort immediately, including from FAIL.

Verification (DCM_RST_CYCLES=8, LOCK_TIMEOUT=32, STABLE_CYCLES=16, MAX_RETRIES=2)
REQ-032 Nominal: release RESET_N, DCM_LOCKED=1 at cycle 20 -> DCM_RST high cycles 0-7, WB_RST falls 3 cycles after DCM_LOCKED, WB_RST_DELAY falls 16 cycles later, STATE=3.
REQ-033 Timeout/retry: DCM_LOCKED held 0 -> three DCM_RST pulses, RETRY_CNT 0->1->2, then STATE=4, LOCK_FAIL=1.
REQ-034 Recovery: in FAIL pulse SOFT_RST, then DCM_LOCKED=1 -> LOCK_FAIL=0, RETRY_CNT=0, reaches RUN.
REQ-035 Lock loss: in RUN drop DCM_LOCKED -> within 3 cycles WB_RST=1, WB_RST_DELAY=1, DCM_RST=1, RETRY_CNT unchanged.
REQ-036 Glitch in STABLE: DCM_LOCKED low 1 cycle at STABLE cycle 10 -> back to DCM_RST_S, WB_RST_DELAY never falls.
REQ-037 Simultaneous: SOFT_RST on the timeout cycle with RETRY_CNT=2 -> DCM_RST_S, RETRY_CNT=0, LOCK_FAIL stays 0.

Source files
------------

// File: rtl/dcm_reset_sequencer.sv
// rtl/dcm_reset_sequencer.sv - DCM reset/lock sequencer with retry, stability window and sticky failure
module dcm_reset_sequencer #(
  parameter int DCM_RST_CYCLES = 128,
  parameter int LOCK_TIMEOUT   = 4096,
  parameter int STABLE_CYCLES  = 2048,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       PCI_CLK,
  input  logic       RESET_N,
  input  logic       SOFT_RST,
  input  logic       DCM_LOCKED,
  output logic       DCM_RST,
  output logic       WB_RST,
  output logic       WB_RST_DELAY,
  output logic       LOCK_FAIL,
  output logic [1:0] RETRY_CNT,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    ST_DCM_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  // Terminal counts: the counter starts at 0 on state entry, so the last cycle is N-1
  localparam logic [15:0] DCM_LAST    = 16'(DCM_RST_CYCLES - 1);
  localparam logic [15:0] LOCK_LAST   = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
  localparam logic [1:0]  RETRY_MAX   = 2'(MAX_RETRIES);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  retry_q, retry_d;
  logic        lock_fail_q, lock_fail_d;
  logic        dcm_rst_q, dcm_rst_d;
  logic        wb_rst_q, wb_rst_d;
  logic        wb_rst_delay_q, wb_rst_delay_d;
  logic        lk_meta_q, lk_q;

  // Two-flop synchronizer for the asynchronous DCM lock flag
  always_ff @(posedge PCI_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      lk_meta_q <= 1'b0;
      lk_q      <= 1'b0;
    end else begin
      lk_meta_q <= DCM_LOCKED;
      lk_q      <= lk_meta_q;
    end
  end

  // Next state, cycle counter, retry count and sticky failure; soft restart overrides everything
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 16'd1;
    retry_d     = retry_q;
    lock_fail_d = lock_fail_q;
    if (SOFT_RST) begin
      state_d     = ST_DCM_RST;
      cnt_d       = 16'd0;
      retry_d     = 2'd0;
      lock_fail_d = 1'b0;
    end else begin
      case (state_q)
        ST_DCM_RST: begin
          if (cnt_q == DCM_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = 16'd0;
          end
        end
        ST_WAIT_LOCK: begin
          if (lk_q) begin
            state_d = ST_STABLE;
            cnt_d   = 16'd0;
          end else if (cnt_q == LOCK_LAST) begin
            cnt_d = 16'd0;
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 2'd1;
              state_d = ST_DCM_RST;
            end else begin
              state_d     = ST_FAIL;
              lock_fail_d = 1'b1;
            end
          end
        end
        ST_STABLE: begin
          if (!lk_q) begin
            state_d = ST_DCM_RST;
            cnt_d   = 16'd0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = 16'd0;
            retry_d = 2'd0;
          end
        end
        ST_RUN: begin
          cnt_d = cnt_q;
          if (!lk_q) begin
            state_d = ST_DCM_RST;
            cnt_d   = 16'd0;
          end
        end
        ST_FAIL: begin
          cnt_d       = cnt_q;
          lock_fail_d = 1'b1;
        end
        default: begin
          state_d = ST_DCM_RST;
          cnt_d   = 16'd0;
        end
      endcase
    end
    // Reset outputs are decoded from the next state so they switch with STATE
    dcm_rst_d      = (state_d == ST_DCM_RST) || (state_d == ST_FAIL);
    wb_rst_d       = (state_d != ST_STABLE) && (state_d != ST_RUN);
    wb_rst_delay_d = (state_d != ST_RUN);
  end

  // State, counter and registered outputs
  always_ff @(posedge PCI_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q        <= ST_DCM_RST;
      cnt_q          <= 16'd0;
      retry_q        <= 2'd0;
      lock_fail_q    <= 1'b0;
      dcm_rst_q      <= 1'b1;
      wb_rst_q       <= 1'b1;
      wb_rst_delay_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      retry_q        <= retry_d;
      lock_fail_q    <= lock_fail_d;
      dcm_rst_q      <= dcm_rst_d;
      wb_rst_q       <= wb_rst_d;
      wb_rst_delay_q <= wb_rst_delay_d;
    end
  end

  assign DCM_RST      = dcm_rst_q;
  assign WB_RST       = wb_rst_q;
  assign WB_RST_DELAY = wb_rst_delay_q;
  assign LOCK_FAIL    = lock_fail_q;
  assign RETRY_CNT    = retry_q;
  assign STATE        = state_q;

endmodule

// File: tb/tb_dcm_reset_sequencer.sv
// tb/tb_dcm_reset_sequencer.sv - scoreboard bench for dcm_reset_sequencer
module tb_dcm_reset_sequencer;

  logic       PCI_CLK = 1'b0;
  logic       RESET_N;
  logic       SOFT_RST;
  logic       DCM_LOCKED;
  logic       DCM_RST;
  logic       WB_RST;
  logic       WB_RST_DELAY;
  logic       LOCK_FAIL;
  logic [1:0] RETRY_CNT;
  logic [2:0] STATE;

  dcm_reset_sequencer #(
    .DCM_RST_CYCLES(8),
    .LOCK_TIMEOUT(32),
    .STABLE_CYCLES(16),
    .MAX_RETRIES(2)
  ) dut (
    .PCI_CLK(PCI_CLK),
    .RESET_N(RESET_N),
    .SOFT_RST(SOFT_RST),
    .DCM_LOCKED(DCM_LOCKED),
    .DCM_RST(DCM_RST),
    .WB_RST(WB_RST),
    .WB_RST_DELAY(WB_RST_DELAY),
    .LOCK_FAIL(LOCK_FAIL),
    .RETRY_CNT(RETRY_CNT),
    .STATE(STATE)
  );

  always #5 PCI_CLK = ~PCI_CLK;

  typedef struct {
    int         cyc;
    logic [8:0] v;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   b1;
  int   b2;

  always @(posedge PCI_CLK) cyc <= cyc + 1;

  // Expected vector: {STATE, RETRY_CNT, LOCK_FAIL, DCM_RST, WB_RST, WB_RST_DELAY}
  function automatic logic [8:0] ev(input int st, input int rc, input bit lf,
                                    input bit dr, input bit wr, input bit wd);
    return {3'(st), 2'(rc), lf, dr, wr, wd};
  endfunction

  task automatic push_range(input int base, input int from, input int to,
                            input logic [8:0] v, input string nm);
    for (int c = from; c <= to; c++) sb.push_back('{base + c, v, nm});
  endtask

  task automatic goto_cyc(input int t);
    while (cyc < t) begin
      @(posedge PCI_CLK);
      #1;
    end
  endtask

  // Monitor: pop and compare every expectation due in the current cycle
  always @(negedge PCI_CLK) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      checks = checks + 1;
      if (mon_e.cyc < cyc) begin
        errors = errors + 1;
        $display("FAIL %s missed cyc=%0d now=%0d", mon_e.nm, mon_e.cyc, cyc);
      end else if ({STATE, RETRY_CNT, LOCK_FAIL, DCM_RST, WB_RST, WB_RST_DELAY} !== mon_e.v) begin
        errors = errors + 1;
        $display("FAIL %s cyc=%0d got=%b required=%b", mon_e.nm, cyc,
                 {STATE, RETRY_CNT, LOCK_FAIL, DCM_RST, WB_RST, WB_RST_DELAY}, mon_e.v);
      end
    end
  end

  initial begin
    RESET_N    = 1'b0;
    SOFT_RST   = 1'b0;
    DCM_LOCKED = 1'b0;
    push_range(0, 2, 3, ev(0, 0, 0, 1, 1, 1), "reset_state");
    goto_cyc(5);

    // Nominal lock, lock loss in RUN, glitch in STABLE, relock, async reset from RUN
    b1 = cyc;
    push_range(b1, 0, 7, ev(0, 0, 0, 1, 1, 1), "nom_dcm_rst");
    push_range(b1, 8, 22, ev(1, 0, 0, 0, 1, 1), "nom_wait_lock");
    push_range(b1, 23, 38, ev(2, 0, 0, 0, 0, 1), "nom_stable");
    push_range(b1, 39, 52, ev(3, 0, 0, 0, 0, 0), "nom_run");
    push_range(b1, 53, 60, ev(0, 0, 0, 1, 1, 1), "loss_dcm_rst");
    push_range(b1, 61, 64, ev(1, 0, 0, 0, 1, 1), "loss_wait_lock");
    push_range(b1, 65, 77, ev(2, 0, 0, 0, 0, 1), "glitch_stable");
    push_range(b1, 78, 85, ev(0, 0, 0, 1, 1, 1), "glitch_dcm_rst");
    push_range(b1, 86, 86, ev(1, 0, 0, 0, 1, 1), "glitch_wait_lock");
    push_range(b1, 87, 102, ev(2, 0, 0, 0, 0, 1), "relock_stable");
    push_range(b1, 103, 107, ev(3, 0, 0, 0, 0, 0), "relock_run");
    push_range(b1, 108, 110, ev(0, 0, 0, 1, 1, 1), "async_rst_run");
    RESET_N = 1'b1;
    goto_cyc(b1 + 20);  DCM_LOCKED = 1'b1;
    goto_cyc(b1 + 50);  DCM_LOCKED = 1'b0;
    goto_cyc(b1 + 62);  DCM_LOCKED = 1'b1;
    goto_cyc(b1 + 75);  DCM_LOCKED = 1'b0;
    goto_cyc(b1 + 76);  DCM_LOCKED = 1'b1;
    goto_cyc(b1 + 108); RESET_N = 1'b0; DCM_LOCKED = 1'b0;
    goto_cyc(b1 + 111);

    // Timeouts to FAIL, soft recovery, soft on timeout cycle, FAIL again, async reset from FAIL
    b2 = cyc;
    push_range(b2, 0, 7, ev(0, 0, 0, 1, 1, 1), "to_dcm_rst_r0");
    push_range(b2, 8, 39, ev(1, 0, 0, 0, 1, 1), "to_wait_r0");
    push_range(b2, 40, 47, ev(0, 1, 0, 1, 1, 1), "to_dcm_rst_r1");
    push_range(b2, 48, 79, ev(1, 1, 0, 0, 1, 1), "to_wait_r1");
    push_range(b2, 80, 87, ev(0, 2, 0, 1, 1, 1), "to_dcm_rst_r2");
    push_range(b2, 88, 119, ev(1, 2, 0, 0, 1, 1), "to_wait_r2");
    push_range(b2, 120, 126, ev(4, 2, 1, 1, 1, 1), "fail_hold");
    push_range(b2, 127, 134, ev(0, 0, 0, 1, 1, 1), "soft_dcm_rst");
    push_range(b2, 135, 135, ev(1, 0, 0, 0, 1, 1), "soft_wait_lock");
    push_range(b2, 136, 151, ev(2, 0, 0, 0, 0, 1), "soft_stable");
    push_range(b2, 152, 158, ev(3, 0, 0, 0, 0, 0), "soft_run");
    push_range(b2, 159, 166, ev(0, 0, 0, 1, 1, 1), "sim_dcm_rst_r0");
    push_range(b2, 167, 198, ev(1, 0, 0, 0, 1, 1), "sim_wait_r0");
    push_range(b2, 199, 206, ev(0, 1, 0, 1, 1, 1), "sim_dcm_rst_r1");
    push_range(b2, 207, 238, ev(1, 1, 0, 0, 1, 1), "sim_wait_r1");
    push_range(b2, 239, 246, ev(0, 2, 0, 1, 1, 1), "sim_dcm_rst_r2");
    push_range(b2, 247, 278, ev(1, 2, 0, 0, 1, 1), "sim_wait_r2");
    push_range(b2, 279, 288, ev(0, 0, 0, 1, 1, 1), "soft_on_timeout");
    push_range(b2, 289, 320, ev(1, 0, 0, 0, 1, 1), "re_wait_r0");
    push_range(b2, 321, 328, ev(0, 1, 0, 1, 1, 1), "re_dcm_rst_r1");
    push_range(b2, 329, 360, ev(1, 1, 0, 0, 1, 1), "re_wait_r1");
    push_range(b2, 361, 368, ev(0, 2, 0, 1, 1, 1), "re_dcm_rst_r2");
    push_range(b2, 369, 400, ev(1, 2, 0, 0, 1, 1), "re_wait_r2");
    push_range(b2, 401, 404, ev(4, 2, 1, 1, 1, 1), "re_fail");
    push_range(b2, 405, 407, ev(0, 0, 0, 1, 1, 1), "async_rst_fail");
    RESET_N = 1'b1;
    goto_cyc(b2 + 126); SOFT_RST = 1'b1;
    goto_cyc(b2 + 127); SOFT_RST = 1'b0;
    goto_cyc(b2 + 130); DCM_LOCKED = 1'b1;
    goto_cyc(b2 + 156); DCM_LOCKED = 1'b0;
    goto_cyc(b2 + 278); SOFT_RST = 1'b1;
    goto_cyc(b2 + 281); SOFT_RST = 1'b0;
    goto_cyc(b2 + 405); RESET_N = 1'b0;
    goto_cyc(b2 + 410);

    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
